rr_arbiter: RTL and testbench

Round-robin arbiter with valid/ready handshakes. It selects one of `NUM_REQ` requesters per transfer and registers the winner's payload in a single output stage. It also registers the one-hot grant and the binary grant index, so downstream logic can mux or route without re-encoding. It sits in front of shared resources such as memory ports and bus masters, with the one-hot-to-binary encoder embedded in its grant path.

---
 rtl/rr_arbiter_pkg.sv | 9 +
 rtl/oh_to_binary.sv | 17 +
 rtl/rr_arbiter.sv | 109 ++++++++++
 tb/tb_rr_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared helpers for the round-robin arbiter.
package rr_arbiter_pkg;

  // Modulo-n increment used to advance the priority pointer past the winner.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/oh_to_binary.sv
// One-hot to binary encoder; the output is zero when the input is all-zero.
module oh_to_binary #(
  parameter  int INPUT_WIDTH  = 4,
  localparam int OUTPUT_WIDTH = $clog2(INPUT_WIDTH)
) (
  input  logic [INPUT_WIDTH-1:0]  oh_in,
  output logic [OUTPUT_WIDTH-1:0] bin_out
);

  always_comb begin
    bin_out = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      if (oh_in[i]) bin_out |= OUTPUT_WIDTH'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a single registered output stage carrying payload,
// one-hot grant and binary grant index.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [DATA_WIDTH-1:0] req_data [NUM_REQ],
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_REQ-1:0]    out_grant_oh,
  output logic [IDX_WIDTH-1:0]  out_grant_idx
);

  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [NUM_REQ-1:0]    out_grant_oh_q, out_grant_oh_d;
  logic [IDX_WIDTH-1:0]  out_grant_idx_q, out_grant_idx_d;

  logic [2*NUM_REQ-1:0]  dbl_masked;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_WIDTH-1:0]  gnt_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  can_accept;
  logic                  found;

  assign can_accept = !out_valid_q || out_ready;

  // Lower copy masked below ptr, upper copy unmasked: first set bit is the
  // winner in rotated order, folded back with a modulo.
  always_comb begin
    dbl_masked = '0;
    for (int j = 0; j < 2*NUM_REQ; j++) begin
      dbl_masked[j] = req_valid[j % NUM_REQ] && (j >= int'(ptr_q));
    end
    gnt   = '0;
    found = 1'b0;
    for (int j = 0; j < 2*NUM_REQ; j++) begin
      if (dbl_masked[j] && !found) begin
        found            = 1'b1;
        gnt[j % NUM_REQ] = 1'b1;
      end
    end
  end

  oh_to_binary #(
    .INPUT_WIDTH (NUM_REQ)
  ) u_oh_to_binary (
    .oh_in   (gnt),
    .bin_out (gnt_idx)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) win_data |= req_data[i];
    end
  end

  assign req_ready = can_accept ? gnt : '0;

  always_comb begin
    ptr_d           = ptr_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_grant_oh_d  = out_grant_oh_q;
    out_grant_idx_d = out_grant_idx_q;
    if (can_accept && found) begin
      out_valid_d     = 1'b1;
      out_data_d      = win_data;
      out_grant_oh_d  = gnt;
      out_grant_idx_d = gnt_idx;
      ptr_d           = IDX_WIDTH'(rr_next(int'(gnt_idx), NUM_REQ));
    end else if (out_valid_q && out_ready) begin
      out_valid_d    = 1'b0;
      out_grant_oh_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q           <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_grant_oh_q  <= '0;
      out_grant_idx_q <= '0;
    end else begin
      ptr_q           <= ptr_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_grant_oh_q  <= out_grant_oh_d;
      out_grant_idx_q <= out_grant_idx_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_grant_oh  = out_grant_oh_q;
  assign out_grant_idx = out_grant_idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios plus random traffic on a 4-way and
// a 3-way instance, each compared against a rotating-scan reference model.
module tb_rr_arbiter;

  typedef struct {
    bit          v;
    logic [31:0] d;
    logic [3:0]  oh;
    int          idx;
    int          ptr;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_data [4];
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_grant_oh;
  logic [1:0]  out_grant_idx;

  logic [2:0]  v3, rr3;
  logic [31:0] d3 [3];
  logic        ov3, ordy3;
  logic [31:0] od3;
  logic [2:0]  oh3;
  logic [1:0]  idx3;

  int   n_pass  = 0;
  int   n_total = 0;
  mdl_t m4, m3;

  rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_grant_oh  (out_grant_oh),
    .out_grant_idx (out_grant_idx)
  );

  rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32)) dut3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (v3),
    .req_data      (d3),
    .req_ready     (rr3),
    .out_valid     (ov3),
    .out_ready     (ordy3),
    .out_data      (od3),
    .out_grant_oh  (oh3),
    .out_grant_idx (idx3)
  );

  function automatic mdl_t mreset();
    mdl_t m;
    m.v = 1'b0; m.d = '0; m.oh = '0; m.idx = 0; m.ptr = 0;
    return m;
  endfunction

  // First valid requester scanning ptr, ptr+1, ... modulo n; -1 if none.
  function automatic int mwin(logic [3:0] v, int p, int n);
    for (int k = 0; k < n; k++) begin
      if (v[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] mready(mdl_t m, logic [3:0] v, bit rdy, int n);
    int w;
    w = mwin(v, m.ptr, n);
    if ((!m.v || rdy) && w >= 0) return 4'(1) << w;
    return 4'b0;
  endfunction

  function automatic mdl_t mstep(mdl_t m, logic [3:0] v, logic [31:0] d [4], bit rdy, int n);
    mdl_t r;
    int   w;
    r = m;
    w = mwin(v, m.ptr, n);
    if ((!m.v || rdy) && w >= 0) begin
      r.v = 1'b1; r.d = d[w]; r.oh = 4'(1) << w; r.idx = w; r.ptr = (w + 1) % n;
    end else if (m.v && rdy) begin
      r.v = 1'b0; r.oh = '0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out4();
    chk("out_valid", 64'(out_valid), 64'(m4.v));
    chk("out_data", 64'(out_data), 64'(m4.d));
    chk("out_grant_oh", 64'(out_grant_oh), 64'(m4.oh));
    chk("out_grant_idx", 64'(out_grant_idx), 64'(m4.idx));
  endtask

  task automatic chk_out3();
    chk("out_valid3", 64'(ov3), 64'(m3.v));
    chk("out_data3", 64'(od3), 64'(m3.d));
    chk("out_grant_oh3", 64'({1'b0, oh3}), 64'(m3.oh));
    chk("out_grant_idx3", 64'(idx3), 64'(m3.idx));
  endtask

  task automatic cyc4(input logic [3:0] v, input bit rdy);
    req_valid = v;
    out_ready = rdy;
    #1;
    chk("req_ready", 64'(req_ready), 64'(mready(m4, v, rdy, 4)));
    @(posedge clk);
    m4 = mstep(m4, v, req_data, rdy, 4);
    #1;
    chk_out4();
  endtask

  task automatic cyc3(input logic [2:0] v, input bit rdy);
    logic [31:0] dd [4];
    v3    = v;
    ordy3 = rdy;
    dd[0] = d3[0]; dd[1] = d3[1]; dd[2] = d3[2]; dd[3] = '0;
    #1;
    chk("req_ready3", 64'({1'b0, rr3}), 64'(mready(m3, {1'b0, v}, rdy, 3)));
    @(posedge clk);
    m3 = mstep(m3, {1'b0, v}, dd, rdy, 3);
    #1;
    chk_out3();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m4 = mreset();
    m3 = mreset();
    chk_out4();
    chk_out3();
    chk("rst_req_ready", 64'(req_ready), 64'(mready(m4, req_valid, out_ready, 4)));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i] = '0;
    v3 = '0; ordy3 = 1'b0;
    for (int i = 0; i < 3; i++) d3[i] = '0;
    #3;
    do_reset();

    // Reset while a transfer is held under backpressure.
    req_data[2] = 32'hAA;
    cyc4(4'b0100, 1'b0);
    chk("capture_aa", 64'(out_data), 64'hAA);
    cyc4(4'b0100, 1'b0);
    do_reset();
    chk("midstall_valid", 64'(out_valid), 64'h0);
    cyc4(4'b1110, 1'b1);
    chk("post_reset_idx", 64'(out_grant_idx), 64'd1);

    // Full contention from a fresh pointer.
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i] = 32'h100 + 32'(i);
    for (int i = 0; i < 8; i++) begin
      cyc4(4'b1111, 1'b1);
      chk("contention_idx", 64'(out_grant_idx), 64'(i % 4));
      chk("contention_oh", 64'(out_grant_oh), 64'(4'(1) << (i % 4)));
    end

    // Backpressure on a lone requester.
    cyc4(4'b0000, 1'b1);
    req_data[1] = 32'h11;
    cyc4(4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc4(4'b0010, 1'b0);
      chk("bp_data", 64'(out_data), 64'h11);
      chk("bp_ready", 64'(req_ready), 64'h0);
    end
    cyc4(4'b0000, 1'b1);
    chk("bp_single_pop", 64'(out_valid), 64'h0);

    // Skipping idle requesters, then drain without refill.
    cyc4(4'b0001, 1'b1);
    cyc4(4'b1000, 1'b1);
    chk("skip_idx3", 64'(out_grant_idx), 64'd3);
    cyc4(4'b0010, 1'b1);
    chk("skip_idx1", 64'(out_grant_idx), 64'd1);
    cyc4(4'b0000, 1'b1);
    chk("drain_valid", 64'(out_valid), 64'h0);
    chk("drain_oh", 64'(out_grant_oh), 64'h0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) req_data[i] = $urandom();
      cyc4(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end

    // Three requesters: pointer wraps from 2 back to 0.
    req_valid = '0; out_ready = 1'b0;
    do_reset();
    d3[0] = 32'hC0; d3[1] = 32'hC1; d3[2] = 32'hC2;
    cyc3(3'b100, 1'b1);
    chk("n3_idx2", 64'(idx3), 64'd2);
    cyc3(3'b101, 1'b1);
    chk("n3_wrap_idx0", 64'(idx3), 64'd0);
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < 3; i++) d3[i] = $urandom();
      cyc3(3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
